// File: rtl/lp_sample_queue_pkg.sv
// Shared constants and FSM state type for the LP FIR sample queue.
package lp_sample_queue_pkg;

    localparam int DEPTH = 1021;
    localparam int AW    = 10;

    typedef enum logic {
        IDLE,
        SEQ
    } state_e;

endpackage

// File: rtl/lp_sample_queue_ram.sv
// Simple dual-port RAM: one write port and one registered read port, no reset on storage.
module dualport_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lp_sample_queue.sv
// Circular stereo sample queue that replays the newest DEPTH samples, oldest first,
// to the low-pass FIR once per window, with a one-deep pending request.
module lp_sample_queue
    import lp_sample_queue_pkg::*;
#(
    parameter int DEPTH = lp_sample_queue_pkg::DEPTH,
    parameter int AW    = lp_sample_queue_pkg::AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rht_smpl,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rht_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] DEPTH_P = AW'(DEPTH);

    state_e             state_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fill_q, fill_d;
    logic [CW-1:0]      cnt_q;
    logic               pending_q;
    logic               sequencing_q;
    logic signed [15:0] lft_out_q, rht_out_q;
    logic               full;
    logic               start;
    logic               out_en;
    logic [31:0]        rd_data;

    assign full   = (fill_q == DEPTH_C);
    assign out_en = (state_q == SEQ) && (cnt_q != DEPTH_C);

    // The RAM is addressed with the next read pointer so its registered output
    // already holds sample 0 during S0, giving sample k at the outputs in S(k+1).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (wrt_smpl) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != DEPTH_C) begin
                fill_d = fill_q + 1'b1;
            end
        end
        start = (state_q == IDLE) &&
                ((wrt_smpl && (fill_d == DEPTH_C)) || (pending_q && full));
        rd_ptr_d = rd_ptr_q;
        if (start) begin
            rd_ptr_d = wr_ptr_d - DEPTH_P;
        end else if (state_q == SEQ) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            lft_out_q <= '0;
            rht_out_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            if (out_en) begin
                lft_out_q <= rd_data[31:16];
                rht_out_q <= rd_data[15:0];
            end
        end
    end

    // Leaving SEQ always spends one cycle in IDLE, which is the mandatory gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            sequencing_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= SEQ;
                        cnt_q        <= '0;
                        pending_q    <= 1'b0;
                        sequencing_q <= 1'b1;
                    end
                end
                SEQ: begin
                    if (wrt_smpl) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == DEPTH_C) begin
                        state_q      <= IDLE;
                        sequencing_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    sequencing_q <= 1'b0;
                end
            endcase
        end
    end

    dualport_ram #(
        .AW(AW),
        .DW(32)
    ) u_ram (
        .clk    (clk),
        .we_i   (wrt_smpl),
        .waddr_i(wr_ptr_q),
        .wdata_i({lft_smpl, rht_smpl}),
        .raddr_i(rd_ptr_d),
        .rdata_o(rd_data)
    );

    assign sequencing = sequencing_q;
    assign lft_out    = lft_out_q;
    assign rht_out    = rht_out_q;

endmodule

// File: tb/tb_lp_sample_queue.sv
// Scoreboard bench for lp_sample_queue: a sample-history reference model predicts
// every window, and a monitor checks sequencing and each replayed sample.
module tb_lp_sample_queue;

    localparam int DEPTH = 1021;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wrtSmpl = 1'b0;
    logic signed [15:0] lftSmpl = '0;
    logic signed [15:0] rhtSmpl = '0;
    logic               sequencing;
    logic signed [15:0] lftOut;
    logic signed [15:0] rhtOut;

    int vectors = 0;
    int miscompares = 0;

    lp_sample_queue #(.DEPTH(DEPTH), .AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt_smpl  (wrtSmpl),
        .lft_smpl  (lftSmpl),
        .rht_smpl  (rhtSmpl),
        .sequencing(sequencing),
        .lft_out   (lftOut),
        .rht_out   (rhtOut)
    );

    always #5 clk = ~clk;

    // Reference model state: newest DEPTH samples, expected replay queue and window timing.
    logic [31:0] hist[$];
    logic [31:0] expQ[$];
    int cyc = 0;
    int winStart = 0;
    bit hasWin = 0;
    bit pend = 0;
    int written = 0;
    int winCount = 0;

    function automatic bit inWin(int c);
        return hasWin && (c >= winStart) && (c <= winStart + DEPTH);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // A window may start only if the previous cycle was outside a window; it then
    // replays the DEPTH newest samples, including the strobe of that same edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            expQ.delete();
            hasWin  = 0;
            pend    = 0;
            written = 0;
        end else begin
            bit prevIn;
            prevIn = inWin(cyc);
            if (wrtSmpl) begin
                hist.push_back({lftSmpl, rhtSmpl});
                if (hist.size() > DEPTH) void'(hist.pop_front());
                if (written < DEPTH) written++;
            end
            if (!prevIn && ((wrtSmpl && written >= DEPTH) || pend)) begin
                winStart = cyc + 1;
                hasWin   = 1;
                pend     = 0;
                winCount++;
                foreach (hist[k]) expQ.push_back(hist[k]);
            end else if (prevIn && wrtSmpl) begin
                pend = 1;
            end
        end
    end

    // Monitor: checks sequencing every cycle and pops one expected sample per data cycle.
    int dutPos = -1;
    int runLen = 0;
    int dutWins = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            dutPos = -1;
            runLen = 0;
        end else begin
            checkOutput("sequencing", {31'd0, sequencing}, {31'd0, inWin(cyc)});
            if (sequencing) begin
                runLen++;
                dutPos++;
                if (dutPos == 0) dutWins++;
                if (dutPos >= 1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("expected queue underflow", 32'd1, 32'd0);
                    end else begin
                        logic [31:0] e;
                        e = expQ.pop_front();
                        checkOutput($sformatf("sample S%0d", dutPos), {lftOut, rhtOut}, e);
                    end
                end
            end else if (runLen > 0) begin
                checkOutput("window length", runLen, DEPTH + 1);
                runLen = 0;
                dutPos = -1;
            end
        end
    end

    task automatic applyStimulus(input int l, input int r, input int gap);
        @(negedge clk);
        wrtSmpl = 1'b1;
        lftSmpl = 16'(l);
        rhtSmpl = 16'(r);
        @(negedge clk);
        wrtSmpl = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((pend || inWin(cyc)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) checkOutput("idle wait timeout", 32'd1, 32'd0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset sequencing", {31'd0, sequencing}, 32'd0);
        checkOutput("reset lft_out", {16'd0, lftOut}, 32'd0);
        checkOutput("reset rht_out", {16'd0, rhtOut}, 32'd0);
        #2 rst_n = 1'b1;

        $display("[TB] ramp fill, first window");
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(i, -i, $urandom_range(0, 2));
        checkOutput("no window before full", {31'd0, sequencing}, 32'd0);
        applyStimulus(DEPTH - 1, -(DEPTH - 1), 0);
        checkOutput("window rises after last fill strobe", {31'd0, sequencing}, 32'd1);
        waitIdle();

        $display("[TB] 1500-sample run with pointer wrap");
        pulseReset();
        for (int i = 0; i < 1499; i++) applyStimulus(i, int'($urandom_range(0, 65535)), $urandom_range(0, 2));
        waitIdle();
        applyStimulus(1499, int'($urandom_range(0, 65535)), 0);
        checkOutput("wrap window start", {31'd0, sequencing}, 32'd1);
        waitIdle();

        $display("[TB] two strobes inside one window");
        applyStimulus(16'h7000, 16'h1234, 100);
        applyStimulus(16'h7001, 16'h4321, 200);
        applyStimulus(16'h7002, 16'h5a5a, 0);
        waitIdle();

        $display("[TB] reset in the middle of a window");
        applyStimulus(16'h6000, 16'h0bad, 0);
        checkOutput("window before abort", {31'd0, sequencing}, 32'd1);
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort sequencing", {31'd0, sequencing}, 32'd0);
        checkOutput("abort lft_out", {16'd0, lftOut}, 32'd0);
        checkOutput("abort rht_out", {16'd0, rhtOut}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(3000 + i, $urandom_range(0, 65535), $urandom_range(0, 2));
        checkOutput("no window after reset refill", {31'd0, sequencing}, 32'd0);
        applyStimulus(4020, 16'h00ff, 0);
        checkOutput("window after refill", {31'd0, sequencing}, 32'd1);
        waitIdle();
        repeat (5) @(negedge clk);

        checkOutput("window count", dutWins, winCount);
        checkOutput("expected queue drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
